// File: rtl/uart_echo_fifo.sv
// uart_echo_fifo -- UART receiver feeding a FIFO that drains into a UART
// transmitter, so every good received word is echoed back on tx.
//
// Parameters
//   UART_BPS    line baud rate
//   CLK_FREQ    sys_clk frequency in Hz; BIT_CYC = CLK_FREQ/UART_BPS
//   DATA_BITS   data bits per frame (5..9)
//   FIFO_DEPTH  echo buffer entries (power of two, 2..256)
//   PARITY_ODD  0 = even, 1 = odd parity (only with UART_PARITY_EN)
//
// Ports
//   sys_clk     single clock, rising edge
//   sys_rst     synchronous active-high reset
//   rx          asynchronous serial input, idle high
//   tx          serial output, idle high
//   fifo_level  current FIFO occupancy (0..FIFO_DEPTH)
//   overflow    1-cycle pulse when a received word is dropped on a full FIFO
//   frame_err   1-cycle pulse on a bad stop bit
//   parity_err  1-cycle pulse on a parity mismatch (0 without parity)
//
// Build option: define UART_PARITY_EN to add one parity bit after the data
// on both directions and to check it on receive.
module uart_echo_fifo #(
  parameter int UART_BPS   = 9600,
  parameter int CLK_FREQ   = 50_000_000,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst,
  input  logic                          rx,
  output logic                          tx,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          frame_err,
  output logic                          parity_err
);

  localparam int BIT_CYC = CLK_FREQ / UART_BPS;
  localparam int CW      = (BIT_CYC > 2) ? $clog2(BIT_CYC) : 1;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int IW      = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_MID  = CW'(BIT_CYC / 2);
  localparam logic [CW-1:0] CNT_END  = CW'(BIT_CYC - 1);
  localparam logic [IW-1:0] IDX_END  = IW'(DATA_BITS - 1);
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA,
`ifdef UART_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  // ---------------------------------------------------------------- rx sync
  logic       rx_s1, rx_s2, rx_d, rx_armed;
  logic [1:0] sync_vld;
  logic       start_edge;

  // sync_vld marks when rx_s2 holds a real sample rather than its reset
  // value; rx_armed then requires one genuine high before any start, so a
  // line held low across reset is not mistaken for a start bit.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_d     <= 1'b1;
      sync_vld <= 2'b00;
      rx_armed <= 1'b0;
    end else begin
      rx_s1    <= rx;
      rx_s2    <= rx_s1;
      rx_d     <= rx_s2;
      sync_vld <= {sync_vld[0], 1'b1};
      if (sync_vld[1] && rx_s2) rx_armed <= 1'b1;
    end
  end

  assign start_edge = rx_armed && rx_d && !rx_s2;

  // ---------------------------------------------------------------- rx fsm
  state_t                 rx_state, rx_next;
  logic [CW-1:0]          rx_cnt;
  logic [IW-1:0]          rx_idx;
  logic [DATA_BITS-1:0]   rx_shift;
  logic                   rx_mid, rx_end;
  logic                   rx_data_smp, rx_stop_smp;
  logic                   par_bad;
  logic                   wr_pend;
  logic [DATA_BITS-1:0]   wr_data;

  assign rx_mid = (rx_cnt == CNT_MID);
  assign rx_end = (rx_cnt == CNT_END);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rx_state  <= S_IDLE;
      rx_cnt    <= '0;
      rx_idx    <= '0;
      rx_shift  <= '0;
      wr_pend   <= 1'b0;
      wr_data   <= '0;
      frame_err <= 1'b0;
    end else begin
      rx_state <= rx_next;
      rx_cnt   <= (rx_next != rx_state || rx_end || rx_next == S_IDLE) ? '0 : rx_cnt + 1'b1;
      if (rx_state != S_DATA) rx_idx <= '0;
      else if (rx_end)        rx_idx <= rx_idx + 1'b1;
      if (rx_data_smp) rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
      // word lands in the FIFO one cycle after the stop sample
      wr_pend   <= rx_stop_smp && rx_s2 && !par_bad;
      if (rx_stop_smp) wr_data <= rx_shift;
      frame_err <= rx_stop_smp && !rx_s2;
    end
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      S_IDLE:   if (start_edge) rx_next = S_START;
      // start bit high at mid-bit is a glitch: back to idle silently
      S_START:  if (rx_mid && rx_s2) rx_next = S_IDLE;
                else if (rx_end)     rx_next = S_DATA;
`ifdef UART_PARITY_EN
      S_DATA:   if (rx_end && rx_idx == IDX_END) rx_next = S_PARITY;
      S_PARITY: if (rx_end) rx_next = S_STOP;
`else
      S_DATA:   if (rx_end && rx_idx == IDX_END) rx_next = S_STOP;
`endif
      // leave at the stop sample so the next start edge is caught promptly
      S_STOP:   if (rx_mid) rx_next = S_IDLE;
      default:  rx_next = S_IDLE;
    endcase
  end

  always_comb begin
    rx_data_smp = 1'b0;
    rx_stop_smp = 1'b0;
    case (rx_state)
      S_DATA:  rx_data_smp = rx_mid;
      S_STOP:  rx_stop_smp = rx_mid;
      default: ;
    endcase
  end

`ifdef UART_PARITY_EN
  localparam logic PAR_ODD = (PARITY_ODD != 0);
  logic rx_par_bad;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rx_par_bad <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (rx_state == S_PARITY && rx_mid)
        rx_par_bad <= (^rx_shift) ^ rx_s2 ^ PAR_ODD;
      parity_err <= rx_stop_smp && rx_par_bad;
    end
  end
  assign par_bad = rx_par_bad;
`else
  logic unused_par;
  assign unused_par = (PARITY_ODD != 0);
  assign par_bad    = 1'b0;
  assign parity_err = 1'b0;
`endif

  // ---------------------------------------------------------------- fifo
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wptr, rptr;
  logic                 fifo_empty, fifo_full, fifo_wr, tx_pop;
  logic [DATA_BITS-1:0] fifo_rd_data;

  assign fifo_empty   = (fifo_level == '0);
  assign fifo_full    = (fifo_level == LVL_FULL);
  // a pop in the same cycle frees the slot, so a full FIFO can still accept
  assign fifo_wr      = wr_pend && (!fifo_full || tx_pop);
  assign fifo_rd_data = mem[rptr];

  always_ff @(posedge sys_clk) begin
    if (fifo_wr) mem[wptr] <= wr_data;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      overflow <= wr_pend && fifo_full && !tx_pop;
      if (fifo_wr) wptr <= wptr + 1'b1;
      if (tx_pop)  rptr <= rptr + 1'b1;
      case ({fifo_wr, tx_pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------- tx fsm
  state_t               tx_state, tx_next;
  logic [CW-1:0]        tx_cnt;
  logic [IW-1:0]        tx_idx;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_end;
`ifdef UART_PARITY_EN
  logic                 tx_par;
`endif

  assign tx_end = (tx_cnt == CNT_END);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
`ifdef UART_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else begin
      tx_state <= tx_next;
      tx_cnt   <= (tx_next != tx_state || tx_end || tx_state == S_IDLE) ? '0 : tx_cnt + 1'b1;
      if (tx_state != S_DATA) tx_idx <= '0;
      else if (tx_end)        tx_idx <= tx_idx + 1'b1;
      if (tx_pop)                             tx_shift <= fifo_rd_data;
      else if (tx_state == S_DATA && tx_end)  tx_shift <= tx_shift >> 1;
`ifdef UART_PARITY_EN
      if (tx_pop) tx_par <= (^fifo_rd_data) ^ PAR_ODD;
`endif
    end
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      S_IDLE:   if (!fifo_empty) tx_next = S_START;
      S_START:  if (tx_end) tx_next = S_DATA;
`ifdef UART_PARITY_EN
      S_DATA:   if (tx_end && tx_idx == IDX_END) tx_next = S_PARITY;
      S_PARITY: if (tx_end) tx_next = S_STOP;
`else
      S_DATA:   if (tx_end && tx_idx == IDX_END) tx_next = S_STOP;
`endif
      // chain straight into the next start bit when more words wait
      S_STOP:   if (tx_end) tx_next = fifo_empty ? S_IDLE : S_START;
      default:  tx_next = S_IDLE;
    endcase
  end

  always_comb begin
    tx     = 1'b1;
    tx_pop = 1'b0;
    case (tx_state)
      S_IDLE:   tx_pop = !fifo_empty;
      S_START:  tx     = 1'b0;
      S_DATA:   tx     = tx_shift[0];
`ifdef UART_PARITY_EN
      S_PARITY: tx     = tx_par;
`endif
      S_STOP:   tx_pop = tx_end && !fifo_empty;
      default:  ;
    endcase
  end

endmodule

// File: tb/tb_uart_echo_fifo.sv
`timescale 1ns/1ps
module tb_uart_echo_fifo;
  localparam int CLK_FREQ = 1_000_000;
  localparam int UART_BPS = 100_000;
  localparam int BIT      = 10;
`ifdef UART_PARITY_EN
  localparam int NB = 11;
  bit par_flip = 1'b0;
`else
  localparam int NB = 10;
`endif

  logic sys_clk = 1'b0;
  logic rst, rst4, rx, rx4;
  logic tx, tx4, ovf, ovf4, ferr, ferr4, perr, perr4;
  logic [4:0] level;
  logic [2:0] level4;

  always #5 sys_clk = ~sys_clk;

  uart_echo_fifo #(.UART_BPS(UART_BPS), .CLK_FREQ(CLK_FREQ), .DATA_BITS(8),
                   .FIFO_DEPTH(16), .PARITY_ODD(0)) dut (
    .sys_clk(sys_clk), .sys_rst(rst), .rx(rx), .tx(tx), .fifo_level(level),
    .overflow(ovf), .frame_err(ferr), .parity_err(perr));

  uart_echo_fifo #(.UART_BPS(UART_BPS), .CLK_FREQ(CLK_FREQ), .DATA_BITS(8),
                   .FIFO_DEPTH(4), .PARITY_ODD(0)) dut4 (
    .sys_clk(sys_clk), .sys_rst(rst4), .rx(rx4), .tx(tx4), .fifo_level(level4),
    .overflow(ovf4), .frame_err(ferr4), .parity_err(perr4));

  int vec  = 0;
  int errs = 0;
  logic [7:0] q0[$];
  logic [7:0] q4[$];
  int perr_seen = 0;
  int lvl_over  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic get_tx(input bit w);   return w ? tx4 : tx;       endfunction
  function automatic logic get_rst(input bit w);  return w ? rst4 : rst;     endfunction
  function automatic int   get_lvl(input bit w);  return w ? int'(level4) : int'(level); endfunction

  always @(negedge sys_clk) begin
    if (perr || perr4) perr_seen++;
    if (level > 5'd16 || level4 > 3'd4) lvl_over++;
  end

  // serial decoder: samples every cycle of a frame, so bit width and value
  // are both checked against the expected echo queue
  task automatic monitor(input bit w);
    logic [NB-1:0] bits;
    logic [7:0]    exp_b;
    logic          v;
    bit            stable, aborted, have;
    string         pfx;
    pfx = w ? "dut4" : "dut";
    forever begin
      @(negedge sys_clk);
      if (get_tx(w) === 1'b0 && !get_rst(w)) begin
        stable = 1; aborted = 0; bits = '0;
        for (int b = 0; b < NB; b++)
          for (int c = 0; c < BIT; c++) begin
            if (b != 0 || c != 0) @(negedge sys_clk);
            v = get_tx(w);
            if (get_rst(w)) aborted = 1;
            if (c == 0) bits[b] = v;
            else if (v !== bits[b]) stable = 0;
          end
        if (aborted) begin
          if (w) q4.delete(); else q0.delete();
        end else begin
          check({pfx, "_bit_width"}, 32'(stable), 1);
          check({pfx, "_stop_bit"}, 32'(bits[NB-1]), 1);
          have = w ? (q4.size() != 0) : (q0.size() != 0);
          check({pfx, "_frame_expected"}, 32'(have), 1);
          if (have) begin
            exp_b = w ? q4.pop_front() : q0.pop_front();
            check({pfx, "_data"}, 32'(bits[8:1]), 32'(exp_b));
`ifdef UART_PARITY_EN
            check({pfx, "_parity_bit"}, 32'(bits[9]), 32'(^exp_b));
`endif
          end
        end
      end
    end
  endtask

  initial monitor(1'b0);
  initial monitor(1'b1);

  task automatic hold(input bit w, input logic v, input int n);
    if (w) rx4 = v; else rx = v;
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic send(input bit w, input logic [7:0] d, input logic stop_v);
    hold(w, 1'b0, BIT);
    for (int i = 0; i < 8; i++) hold(w, d[i], BIT);
`ifdef UART_PARITY_EN
    hold(w, (^d) ^ par_flip, BIT);
`endif
    hold(w, stop_v, BIT);
    if (w) rx4 = 1'b1; else rx = 1'b1;
  endtask

  task automatic wait_level(input bit w, input int val, input int budget, input string name);
    bit found;
    found = 0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge sys_clk);
      if (get_lvl(w) == val) found = 1;
    end
    check(name, 32'(found), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", vec);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt_a, cnt_b, cnt_c, snap;
    bit found;
    rst = 1; rst4 = 1; rx = 1; rx4 = 1;
    repeat (3) @(posedge sys_clk);
    #1; rst = 0; rst4 = 0;
    @(negedge sys_clk);
    check("rst_tx", 32'(tx), 1);           check("rst4_tx", 32'(tx4), 1);
    check("rst_level", 32'(level), 0);     check("rst4_level", 32'(level4), 0);
    check("rst_overflow", 32'(ovf), 0);    check("rst4_overflow", 32'(ovf4), 0);
    check("rst_frame_err", 32'(ferr), 0);  check("rst4_frame_err", 32'(ferr4), 0);
    check("rst_parity_err", 32'(perr), 0); check("rst4_parity_err", 32'(perr4), 0);
    @(posedge sys_clk); #1;

    // 0xA5 round trip: level pulses to 1, then pop and start bit together
    q0.push_back(8'hA5);
    fork
      send(1'b0, 8'hA5, 1'b1);
      wait_level(1'b0, 1, 150, "a5_level_1");
    join
    @(negedge sys_clk);
    check("a5_level_after_pop", 32'(level), 0);
    check("a5_tx_start", 32'(tx), 0);
    repeat (110) @(posedge sys_clk); #1;

    // 3-cycle low glitch is rejected
    cnt_a = 0; cnt_b = 0; cnt_c = 0;
    hold(1'b0, 1'b0, 3);
    rx = 1'b1;
    repeat (40) begin
      @(negedge sys_clk);
      if (level != 0) cnt_a++;
      if (ferr || perr) cnt_b++;
      if (tx !== 1'b1) cnt_c++;
    end
    check("glitch_no_write", 32'(cnt_a), 0);
    check("glitch_no_err", 32'(cnt_b), 0);
    check("glitch_tx_idle", 32'(cnt_c), 0);
    @(posedge sys_clk); #1;

    // 0x3C with stop=0: one frame_err cycle, nothing stored
    cnt_a = 0; cnt_b = 0;
    fork
      send(1'b0, 8'h3C, 1'b0);
      repeat (140) begin
        @(negedge sys_clk);
        if (ferr) cnt_a++;
        if (level != 0) cnt_b++;
      end
    join
    check("ferr_pulse_cycles", 32'(cnt_a), 1);
    check("ferr_no_write", 32'(cnt_b), 0);
    @(posedge sys_clk); #1;

`ifdef UART_PARITY_EN
    // 0x07 sent with parity bit 0 under even parity
    par_flip = 1'b1;
    cnt_a = 0; cnt_b = 0;
    fork
      send(1'b0, 8'h07, 1'b1);
      repeat (140) begin
        @(negedge sys_clk);
        if (perr) cnt_a++;
        if (level != 0) cnt_b++;
      end
    join
    par_flip = 1'b0;
    check("perr_pulse_cycles", 32'(cnt_a), 1);
    check("perr_no_write", 32'(cnt_b), 0);
    @(posedge sys_clk); #1;
`endif

    // reset during a tx DATA bit
    send(1'b0, 8'h96, 1'b1);
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge sys_clk);
      if (tx === 1'b0) found = 1;
    end
    check("rst_mid_tx_started", 32'(found), 1);
    repeat (30) @(posedge sys_clk);
    #1; rst = 1;
    @(posedge sys_clk);
    #1; rst = 0;
    @(negedge sys_clk);
    check("rst_mid_tx_idle", 32'(tx), 1);
    check("rst_mid_level", 32'(level), 0);
    @(posedge sys_clk); #1;

    // rx held low across reset release must not start a frame
    rx = 1'b0;
    rst = 1;
    repeat (2) @(posedge sys_clk);
    #1; rst = 0;
    cnt_a = 0; cnt_b = 0;
    repeat (150) begin
      @(negedge sys_clk);
      if (ferr) cnt_a++;
      if (level != 0) cnt_b++;
    end
    check("low_rst_no_ferr", 32'(cnt_a), 0);
    check("low_rst_no_write", 32'(cnt_b), 0);
    @(posedge sys_clk); #1;
    hold(1'b0, 1'b1, 20);
    q0.push_back(8'h81);
    send(1'b0, 8'h81, 1'b1);
    repeat (130) @(posedge sys_clk); #1;

    // depth-4 overflow with the drain held off
    force dut4.fifo_empty = 1'b1;
    for (int k = 1; k <= 4; k++) q4.push_back(8'(k));
    cnt_a = 0; snap = -1;
    fork
      begin
        for (int k = 1; k <= 4; k++) send(1'b1, 8'(k), 1'b1);
        fork
          send(1'b1, 8'h05, 1'b1);
          begin repeat (30) @(negedge sys_clk); snap = cnt_a; end
        join
      end
      repeat (560) begin
        @(negedge sys_clk);
        if (ovf4) cnt_a++;
      end
    join
    check("ovf_not_before_5th", 32'(snap), 0);
    check("ovf_pulse_cycles", 32'(cnt_a), 1);
    check("ovf_level_full", 32'(level4), 4);
    release dut4.fifo_empty;
    wait_level(1'b1, 0, 500, "ovf_drain_empty");
    repeat (130) @(posedge sys_clk); #1;

    check("q0_drained", 32'(q0.size()), 0);
    check("q4_drained", 32'(q4.size()), 0);
    check("level_bound", 32'(lvl_over), 0);
`ifndef UART_PARITY_EN
    check("parity_err_const0", 32'(perr_seen), 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule

// File: doc/uart_echo_fifo.md
UART_ECHO_FIFO -- requirements
Module: uart_echo_fifo

Interface
REQ-001 The block SHALL have parameter UART_BPS, default 9600, line baud rate.
REQ-002 The block SHALL have parameter CLK_FREQ, default 50_000_000, sys_clk frequency in Hz.
REQ-003 The block SHALL have parameter DATA_BITS, default 8, data bits per frame, legal 5..9.
REQ-004 The block SHALL have parameter FIFO_DEPTH, default 16, echo buffer entries, power of two, 2..256.
REQ-005 The block SHALL have parameter PARITY_ODD, default 0; 0 = even parity, 1 = odd parity; used only with UART_PARITY_EN.
REQ-006 The block SHALL have port sys_clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-007 The block SHALL have port sys_rst, input, 1 bit, reset; synchronous, active-high.
REQ-008 The block SHALL have port rx, input, 1 bit, asynchronous serial input, idle high.
REQ-009 The block SHALL have port tx, output, 1 bit, serial output, idle high.
REQ-010 The block SHALL have port fifo_level, output, $clog2(FIFO_DEPTH)+1 bits, current FIFO occupancy.
REQ-011 The block SHALL have port overflow, output, 1 bit, one-cycle pulse when a received word is dropped because the FIFO is full.
REQ-012 The block SHALL have port frame_err, output, 1 bit, one-cycle pulse on a bad stop bit.
REQ-013 The block SHALL have port parity_err, output, 1 bit, one-cycle pulse on a parity mismatch; tied 0 when parity is compiled out.

Function
REQ-014 BIT_CYC = CLK_FREQ/UART_BPS (integer division) SHALL set the cycles per bit for both RX and TX.
REQ-015 rx SHALL pass through a two-flop synchronizer; a start SHALL be a synchronized 1->0 transition while RX is IDLE.
REQ-016 RX FSM states SHALL be IDLE, START, DATA, PARITY, STOP; each bit is sampled once, at count BIT_CYC/2 within the bit.
REQ-017 If the start bit samples 1 at mid-bit, RX SHALL return to IDLE with no write and no error pulse (glitch rejection).
REQ-018 Data SHALL be received LSB first into a DATA_BITS-wide word.
REQ-019 Stop sampled 0 SHALL pulse frame_err, discard the word, and return RX to IDLE immediately.
REQ-020 Parity mismatch SHALL pulse parity_err at the stop-bit sample and discard the word; a frame with both errors pulses both flags.
REQ-021 A valid word SHALL be written to the FIFO in the cycle after the stop-bit sample; RX SHALL then accept a new start edge.
REQ-022 A write while full SHALL be dropped with an overflow pulse and FIFO contents unchanged, unless a read occurs in the same cycle, in which case the write SHALL be accepted and fifo_level stays FIFO_DEPTH.
REQ-023 A simultaneous read and write when non-empty SHALL leave fifo_level unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-024 TX FSM states SHALL be IDLE, START, DATA, PARITY, STOP; in IDLE with FIFO non-empty, TX SHALL pop one word and drive the start bit in the next cycle.
REQ-025 Each TX bit SHALL last exactly BIT_CYC cycles; data goes out LSB first; one stop bit; frames with a non-empty FIFO SHALL be back-to-back with no idle gap.
REQ-026 The FIFO SHALL never be read while empty; fifo_level SHALL never exceed FIFO_DEPTH.

Reset
REQ-027 When sys_rst is high at a clock edge, the block SHALL set tx=1, fifo_level=0, overflow=0, frame_err=0, parity_err=0, both FSMs to IDLE, all counters to 0, and both synchronizer flops to 1.
REQ-028 Reset mid-frame SHALL abandon the frame and empty the FIFO; rx held low across reset release SHALL NOT be taken as a start until it has first been sampled high.

Configuration
REQ-029 With macro UART_PARITY_EN defined, each frame SHALL carry one parity bit (per PARITY_ODD) after the data on both RX and TX, and parity is checked on RX.
REQ-030 Without UART_PARITY_EN, the PARITY states SHALL be absent, frames are start+DATA_BITS+stop, and parity_err SHALL be constant 0.

Verification (CLK_FREQ=1_000_000, UART_BPS=100_000, so BIT_CYC=10)
REQ-031 The bench SHALL cover: rx frame 0xA5 -> fifo_level 1, then tx emits start, 1,0,1,0,0,1,0,1, stop, 10 cycles per bit, with fifo_level 0 after the pop.
REQ-032 The bench SHALL cover: rx 0 for 3 cycles, then 1 -> no write, no error pulse, tx stays 1.
REQ-033 The bench SHALL cover: frame 0x3C with stop=0 -> single-cycle frame_err, fifo_level stays 0.
REQ-034 The bench SHALL cover: FIFO_DEPTH=4 with tx drain blocked by 5 back-to-back frames 0x01..0x05 -> overflow on 0x05 when no pop coincides, echo order 0x01..0x04.
REQ-035 The bench SHALL cover: UART_PARITY_EN with PARITY_ODD=0 and frame 0x07 with parity bit 0 -> parity_err pulse and no write.
REQ-036 The bench SHALL cover: sys_rst asserted during the DATA state of a tx frame -> tx=1 and fifo_level=0 in the cycle after the reset edge.
